// File: rtl/lcd_panel_responder_if.sv
// rtl/lcd_panel_responder_if.sv - KS0108-style LCD bus bundle between a panel controller and the responder
// master: drives strobe, DI/RW, data and the active-low chip selects; receives the read response.
// slave: the responder side of the same signals.
interface lcd_panel_responder_if;
  logic       LCD_E_STB;
  logic       LCD_DI;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;
  logic       LCD_CS1;
  logic       LCD_CS2;
  logic [7:0] LCD_DOUT;
  logic       LCD_DOUT_VLD;

  modport master (
    output LCD_E_STB, LCD_DI, LCD_RW, LCD_DATA, LCD_CS1, LCD_CS2,
    input  LCD_DOUT, LCD_DOUT_VLD
  );

  modport slave (
    input  LCD_E_STB, LCD_DI, LCD_RW, LCD_DATA, LCD_CS1, LCD_CS2,
    output LCD_DOUT, LCD_DOUT_VLD
  );
endinterface

// File: rtl/lcd_panel_responder.sv
// rtl/lcd_panel_responder.sv - two-chip 128x64 KS0108-style LCD bus responder with registered pixel port
// Optional feature macro: LCD_PROTO_CHECK_EN builds the sticky PROTO_ERR checker.
// Ports:
//   LCD_CLK, RESETN      clock (rising edge) and asynchronous active-low reset
//   bus (slave)          strobe, DI/RW, data, CS1/CS2 in; DOUT/DOUT_VLD read response out
//   PIX_X, PIX_Y         pixel column 0-127 and physical row 0-63
//   PIX_ON               pixel value for the address presented one cycle earlier
//   PROTO_ERR            sticky protocol error (0 when the checker is not built)
module lcd_panel_responder #(
  parameter int unsigned ROWS             = 64,
  parameter int unsigned COLS             = 64,
  parameter int unsigned STATUS_RESET_CYC = 4
) (
  input  logic                 LCD_CLK,
  input  logic                 RESETN,
  lcd_panel_responder_if.slave bus,
  input  logic [6:0]           PIX_X,
  input  logic [5:0]           PIX_Y,
  output logic                 PIX_ON,
  output logic                 PROTO_ERR
);

  localparam int unsigned LW  = $clog2(ROWS);
  localparam int unsigned YW  = $clog2(COLS);
  localparam int unsigned AW  = 3 + YW;
  localparam int unsigned RCW = (STATUS_RESET_CYC < 1) ? 1 : $clog2(STATUS_RESET_CYC + 1);

  // Per-chip state, index 0 = CS1 (left), 1 = CS2 (right)
  logic [1:0]         disp_on_q, disp_on_d;
  logic [1:0][LW-1:0] start_line_q, start_line_d;
  logic [1:0][2:0]    page_q, page_d;
  logic [1:0][YW-1:0] y_q, y_d;
  logic [1:0][7:0]    latch_q, latch_d;
  logic [RCW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [7:0]         dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               pix_on_q, pix_on_d;

  // Display RAM: address = {page, y}
  logic [7:0]         mem [2][1 << AW];

  logic [1:0]         sel;
  logic               any_sel;
  logic               acc;
  logic               instr_wr;
  logic               data_wr;
  logic               data_rd;
  logic               rd_acc;
  logic               rsel;
  logic [1:0][7:0]    rd_byte;

  logic               pchip;
  logic [LW-1:0]      pline;
  logic [7:0]         pbyte;

  assign sel      = {~bus.LCD_CS2, ~bus.LCD_CS1};
  assign any_sel  = |sel;
  assign acc      = bus.LCD_E_STB & any_sel;
  assign instr_wr = acc & ~bus.LCD_DI & ~bus.LCD_RW;
  assign data_wr  = acc &  bus.LCD_DI & ~bus.LCD_RW;
  assign data_rd  = acc &  bus.LCD_DI &  bus.LCD_RW;
  assign rd_acc   = acc & bus.LCD_RW;
  // Chip 0 answers whenever CS1 is low, including broadcast reads
  assign rsel     = bus.LCD_CS1;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      rd_byte[c] = mem[c][{page_q[c], y_q[c]}];
    end
  end

  // Pixel lookup reads the RAM before any same-cycle write lands
  assign pchip = PIX_X[6];
  assign pline = PIX_Y + start_line_q[pchip];
  assign pbyte = mem[pchip][{pline[LW-1:LW-3], PIX_X[YW-1:0]}];

  always_comb begin
    disp_on_d    = disp_on_q;
    start_line_d = start_line_q;
    page_d       = page_q;
    y_d          = y_q;
    latch_d      = latch_q;
    rst_cnt_d    = (rst_cnt_q != '0) ? rst_cnt_q - 1'b1 : rst_cnt_q;
    dout_d       = dout_q;
    dout_vld_d   = rd_acc;
    pix_on_d     = disp_on_q[pchip] & pbyte[pline[2:0]];

    for (int c = 0; c < 2; c++) begin
      if (sel[c]) begin
        if (instr_wr) begin
          if (bus.LCD_DATA[7:1] == 7'b0011111) begin
            disp_on_d[c] = bus.LCD_DATA[0];
          end else if (bus.LCD_DATA[7:6] == 2'b01) begin
            y_d[c] = bus.LCD_DATA[YW-1:0];
          end else if (bus.LCD_DATA[7:3] == 5'b10111) begin
            page_d[c] = bus.LCD_DATA[2:0];
          end else if (bus.LCD_DATA[7:6] == 2'b11) begin
            start_line_d[c] = bus.LCD_DATA[LW-1:0];
          end
        end
        if (data_wr) begin
          y_d[c] = y_q[c] + 1'b1;
        end
        // Dummy-read behaviour: present the old latch, refill it from the current address
        if (data_rd) begin
          latch_d[c] = rd_byte[c];
          y_d[c]     = y_q[c] + 1'b1;
        end
      end
    end

    if (rd_acc) begin
      if (bus.LCD_DI) begin
        dout_d = latch_q[rsel];
      end else begin
        dout_d = {2'b00, ~disp_on_q[rsel], (rst_cnt_q != '0), 4'b0000};
      end
    end
  end

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      disp_on_q    <= '0;
      start_line_q <= '0;
      page_q       <= '0;
      y_q          <= '0;
      latch_q      <= '0;
      rst_cnt_q    <= RCW'(STATUS_RESET_CYC);
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      pix_on_q     <= 1'b0;
    end else begin
      disp_on_q    <= disp_on_d;
      start_line_q <= start_line_d;
      page_q       <= page_d;
      y_q          <= y_d;
      latch_q      <= latch_d;
      rst_cnt_q    <= rst_cnt_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      pix_on_q     <= pix_on_d;
    end
  end

  // RAM keeps its contents through reset; only a write coinciding with reset is dropped
  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (data_wr && sel[c]) begin
          mem[c][{page_q[c], y_q[c]}] <= bus.LCD_DATA;
        end
      end
    end
  end

  assign bus.LCD_DOUT     = dout_q;
  assign bus.LCD_DOUT_VLD = dout_vld_q;
  assign PIX_ON           = pix_on_q;

`ifdef LCD_PROTO_CHECK_EN
  logic proto_err_q;
  logic instr_illegal;
  logic proto_hit;

  always_comb begin
    instr_illegal = !((bus.LCD_DATA[7:1] == 7'b0011111) ||
                      (bus.LCD_DATA[7:6] == 2'b01)      ||
                      (bus.LCD_DATA[7:3] == 5'b10111)   ||
                      (bus.LCD_DATA[7:6] == 2'b11));
    proto_hit = bus.LCD_E_STB & (~any_sel | (rst_cnt_q != '0) | (instr_wr & instr_illegal));
  end

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_q | proto_hit;
    end
  end

  assign PROTO_ERR = proto_err_q;
`else
  assign PROTO_ERR = 1'b0;
`endif

endmodule

// File: doc/lcd_panel_responder.md
Name: lcd_panel_responder

Overview:
- Synthesizable responder for the two-chip 128x64 KS0108-style graphic LCD bus driven by the head/image controllers.
- Decodes instructions and data writes, holds per-chip state and display RAM, and answers status and data reads.
- Also exposes a registered pixel read port so the panel image can be mirrored to a VGA/debug path, or checked in simulation without the physical panel.

Parameters:
- ROWS, 64, visible rows per chip; equals RAM lines; must be 64.
- COLS, 64, columns (Y addresses) per chip; must be 64.
- STATUS_RESET_CYC, 4, cycles after reset during which the status RESET bit reads 1.

Ports:
- LCD_CLK  in  1  bus clock; all logic on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- LCD_E_STB  in  1  ungated enable strobe; one cycle per bus transaction; qualifies all bus inputs in the same cycle.
- LCD_DI  in  1  0 = instruction/status, 1 = data.
- LCD_RW  in  1  0 = write, 1 = read.
- LCD_DATA  in  8  write data or instruction.
- LCD_CS1  in  1  active-low select, left chip (columns 0-63).
- LCD_CS2  in  1  active-low select, right chip (columns 64-127).
- LCD_DOUT  out  8  read response.
- LCD_DOUT_VLD  out  1  high for one cycle when LCD_DOUT is valid.
- PIX_X  in  7  pixel column 0-127.
- PIX_Y  in  6  physical pixel row 0-63.
- PIX_ON  out  1  pixel value for the PIX_X/PIX_Y presented one cycle earlier.
- PROTO_ERR  out  1  sticky protocol error flag; see Optional Feature.

Behaviour:
Per-chip state (chip 0 = CS1, chip 1 = CS2):
- disp_on: 1 bit.
- start_line: 6 bits.
- page: 3 bits.
- y: 6 bits.
- RAM: 8 pages x 64 bytes. RAM contents are not reset.

Reset (asynchronous, RESETN = 0):
- Both chips: disp_on = 0, start_line = 0, page = 0, y = 0.
- Outputs: LCD_DOUT = 0, LCD_DOUT_VLD = 0, PIX_ON = 0, PROTO_ERR = 0.
- Both chips' output latches cleared to 0.
- A reset counter starts loading STATUS_RESET_CYC.

Transaction acceptance:
- A transaction is accepted only when LCD_E_STB = 1 at a rising edge of LCD_CLK.
- Each chip acts when its CS is 0. Both CS low: both chips act (broadcast write).
- Both CS high: the transaction is ignored, with no read response.

Instruction writes (DI = 0, RW = 0), decoded on LCD_DATA:
- 0011111b: disp_on = b.
- 01yyyyyy: y = yyyyyy.
- 10111ppp: page = ppp.
- 11llllll: start_line = llllll.
- Any other value: ignored; no state change.

Data write (DI = 1, RW = 0):
- RAM[page][y] = LCD_DATA.
- Then y = y + 1, wrapping 63 to 0.
- page is never incremented.

Status read (DI = 0, RW = 1):
- Next cycle: LCD_DOUT = {BUSY = 0, 0, ONOFF = ~disp_on, RESET = (reset counter != 0), 4'b0000}, LCD_DOUT_VLD = 1.
- Status comes from chip 0 if CS1 = 0, otherwise from chip 1.

Data read (DI = 1, RW = 1), KS0108 dummy-read semantics:
- LCD_DOUT = the chip's output latch (the dummy value on the first read after an address set).
- In the same cycle, the latch loads RAM[page][y], and y increments with wrap.
- Response is 1-cycle latency with LCD_DOUT_VLD = 1.
- If both CS are low, chip 0 supplies LCD_DOUT; both chips advance y.

Pixel port:
- Chip = PIX_X[6]; col = PIX_X[5:0].
- line = (PIX_Y + start_line) mod 64.
- PIX_ON = disp_on & RAM[line[5:3]][col][line[2:0]], registered, 1-cycle latency.
- A bus write and a pixel read to the same byte in the same cycle returns the old data (read-before-write).

Mid-transaction reset:
- RESETN asserted on the cycle of a strobe: the transaction is discarded.
- LCD_DOUT_VLD stays 0.

Optional Feature:
Macro LCD_PROTO_CHECK_EN.
- Defined: PROTO_ERR sets (sticky until reset) on any of:
  - an illegal instruction code;
  - a strobe with both CS high;
  - a strobe while the reset counter is nonzero.
- Defined: the illegal instruction is still ignored.
- Not defined: PROTO_ERR is tied to 0 and no check logic is built.

Test Plan:
- Reset, then status read on CS1 -> LCD_DOUT = 8'h30 (OFF + RESET) within STATUS_RESET_CYC; 8'h20 after it; after 0x3F, 8'h00.
- CS1 = 0: 0x3F, 0xB8|3, 0x40|62, then data 0xA5, 0x5A, 0xC3 -> RAM[3][62] = A5, [3][63] = 5A, [3][0] = C3 (wrap); page stays 3.
- Set page 3 / Y 62, then three data reads -> dummy value, then A5, then 5A; LCD_DOUT_VLD pulses each time with 1-cycle latency.
- Both CS low: write 0xFF at page 0 / Y 0 -> PIX_ON = 1 for PIX_X = 0 and PIX_X = 64 at rows 0-7; PIX_X = 1 gives 0.
- Start line 0x C8 (line 8) with RAM[1][0] = 0x01 -> PIX_Y = 0, PIX_X = 0 gives PIX_ON = 1; after 0x3E, gives 0.
- With LCD_PROTO_CHECK_EN: instruction 0x00 -> PROTO_ERR = 1 and stays 1 until RESETN; no state change. Without the macro: PROTO_ERR = 0.
